// File: rtl/miter_pkg.sv
// Shared types for the miter memory scheduler: request record, FSM states
// and divergence causes.
package miter_pkg;

  localparam int MITER_AW = 32;
  localparam int MITER_DW = 64;

  typedef enum logic [1:0] {
    DIV_NONE     = 2'b00,
    DIV_TIMING   = 2'b01,
    DIV_DATA     = 2'b10,
    DIV_PROTOCOL = 2'b11
  } div_cause_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_OTHER,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_DIVERGED
  } sched_state_e;

  typedef struct packed {
    logic [MITER_AW-1:0] addr;
    logic                we;
    logic [MITER_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/miter_mem_scheduler_if.sv
// One request/response channel: a requester (master) issues valid+fields and
// receives ready and a response strobe from the responder (slave).
interface miter_mem_scheduler_if #(
  parameter int AW = 32,
  parameter int DW = 64
) ();

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/miter_req_cmp.sv
// Equality check of two requests; write data only matters when the request
// is a write, since reads carry don't-care data.
module miter_req_cmp
  import miter_pkg::*;
(
  input  mem_req_t i_a,
  input  mem_req_t i_b,
  output logic     o_equal
);

  assign o_equal = (i_a.addr == i_b.addr) &&
                   (i_a.we == i_b.we) &&
                   (!i_a.we || (i_a.wdata == i_b.wdata));

endmodule

// File: rtl/miter_mem_scheduler.sv
// Arbitrates one memory port between the two copies of a miter, forwarding a
// request only when both copies agree and latching the first divergence seen.
module miter_mem_scheduler
  import miter_pkg::*;
#(
  parameter int AW       = MITER_AW,
  parameter int DW       = MITER_DW,
  parameter int SKEW_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  miter_mem_scheduler_if.slave  p1,
  miter_mem_scheduler_if.slave  p2,
  miter_mem_scheduler_if.master mem,
  output logic                  diverged,
  output logic [1:0]            div_cause
);

  localparam int SKW = $clog2(SKEW_MAX + 1);
  localparam logic [SKW-1:0] SKEW_LIM = SKW'(SKEW_MAX);

  sched_state_e   r_state;
  div_cause_e     r_cause;
  logic [SKW-1:0] r_skew_cnt;
  logic           r_wait_p2;
  mem_req_t       r_req;
  logic           r_resp_valid;
  logic [DW-1:0]  r_resp_rdata;

  mem_req_t       w_p1_req;
  mem_req_t       w_p2_req;
  logic           w_fields_eq;
  logic           w_both_valid;
  logic           w_wait_drop;
  logic           w_accept;
  logic [SKW:0]   w_skew_next;
  logic           w_skew_hit;

  assign w_p1_req.addr  = p1.req_addr;
  assign w_p1_req.we    = p1.req_we;
  assign w_p1_req.wdata = p1.req_wdata;
  assign w_p2_req.addr  = p2.req_addr;
  assign w_p2_req.we    = p2.req_we;
  assign w_p2_req.wdata = p2.req_wdata;

  miter_req_cmp u_cmp (
    .i_a     (w_p1_req),
    .i_b     (w_p2_req),
    .o_equal (w_fields_eq)
  );

  assign w_both_valid = p1.req_valid && p2.req_valid;
  // A copy that already raised valid must hold it until the other arrives.
  assign w_wait_drop  = (r_state == ST_WAIT_OTHER) &&
                        (r_wait_p2 ? !p2.req_valid : !p1.req_valid);
  assign w_accept     = ((r_state == ST_IDLE) ||
                         ((r_state == ST_WAIT_OTHER) && !w_wait_drop)) &&
                        w_both_valid && w_fields_eq;
  assign w_skew_next  = {1'b0, r_skew_cnt} + (SKW+1)'(1);
  assign w_skew_hit   = (w_skew_next >= (SKW+1)'(SKEW_MAX));

  assign p1.req_ready  = w_accept;
  assign p2.req_ready  = w_accept;
  assign p1.resp_valid = r_resp_valid;
  assign p2.resp_valid = r_resp_valid;
  assign p1.resp_rdata = r_resp_rdata;
  assign p2.resp_rdata = r_resp_rdata;

  assign mem.req_valid = (r_state == ST_ISSUE);
  assign mem.req_addr  = r_req.addr;
  assign mem.req_we    = r_req.we;
  assign mem.req_wdata = r_req.wdata;

  assign diverged  = (r_state == ST_DIVERGED);
  assign div_cause = r_cause;

  // Entry to DIVERGED only happens from IDLE/WAIT_OTHER, so no memory
  // transaction is ever left half-done when the verdict is latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cause      <= DIV_NONE;
      r_skew_cnt   <= '0;
      r_wait_p2    <= 1'b0;
      r_req        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_both_valid) begin
            if (w_fields_eq) begin
              r_req   <= w_p1_req;
              r_state <= ST_ISSUE;
            end else begin
              r_cause <= DIV_DATA;
              r_state <= ST_DIVERGED;
            end
          end else if (p1.req_valid || p2.req_valid) begin
            r_wait_p2  <= p2.req_valid;
            r_skew_cnt <= SKW'(1);
            if (SKEW_MAX <= 1) begin
              r_cause <= DIV_TIMING;
              r_state <= ST_DIVERGED;
            end else begin
              r_state <= ST_WAIT_OTHER;
            end
          end
        end
        ST_WAIT_OTHER: begin
          if (w_wait_drop) begin
            r_cause <= DIV_PROTOCOL;
            r_state <= ST_DIVERGED;
          end else if (w_both_valid) begin
            r_skew_cnt <= '0;
            if (w_fields_eq) begin
              r_req   <= w_p1_req;
              r_state <= ST_ISSUE;
            end else begin
              r_cause <= DIV_DATA;
              r_state <= ST_DIVERGED;
            end
          end else begin
            r_skew_cnt <= w_skew_hit ? SKEW_LIM : w_skew_next[SKW-1:0];
            if (w_skew_hit) begin
              r_cause <= DIV_TIMING;
              r_state <= ST_DIVERGED;
            end
          end
        end
        ST_ISSUE: begin
          if (mem.req_ready) begin
            r_state <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (mem.resp_valid) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= mem.resp_rdata;
            r_state      <= ST_IDLE;
          end
        end
        ST_DIVERGED: begin
          r_state <= ST_DIVERGED;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
